// File: rtl/traffic_display.sv
// traffic_display: scans two snapshotted countdowns onto a 4-digit common-anode 7-segment display with blink.
module traffic_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 32,
  parameter int BLANK_LZ     = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] A_time,
  input  logic [5:0] B_time,
  input  logic       BLINK,
  output logic [3:0] dig_sel,
  output logic [7:0] seg,
  output logic       frame
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] pre_cnt;
  logic [1:0] idx;
  logic [5:0] a_sh, b_sh, v;
  logic [7:0] fcnt;
  logic phase, tick, wrap, blank;
  logic [2:0] tens;
  logic [3:0] ones, dig;
  logic [6:0] code;
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 7'h40;
      4'd1: seg_code = 7'h79;
      4'd2: seg_code = 7'h24;
      4'd3: seg_code = 7'h30;
      4'd4: seg_code = 7'h19;
      4'd5: seg_code = 7'h12;
      4'd6: seg_code = 7'h02;
      4'd7: seg_code = 7'h78;
      4'd8: seg_code = 7'h00;
      4'd9: seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction
  always_comb begin
    tick = pre_cnt == PW'(SCAN_DIV - 1);
    wrap = tick && idx == 2'd3;
    v = idx[1] ? b_sh : a_sh;
    tens = v >= 6'd60 ? 3'd6 : v >= 6'd50 ? 3'd5 : v >= 6'd40 ? 3'd4 :
           v >= 6'd30 ? 3'd3 : v >= 6'd20 ? 3'd2 : v >= 6'd10 ? 3'd1 : 3'd0;
    ones = 4'(v - 6'(tens) * 6'd10);
    dig = idx[0] ? ones : {1'b0, tens};
    code = seg_code(dig);
    blank = (BLANK_LZ != 0 && !idx[0] && tens == 3'd0) || (BLINK && phase);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt <= '0;
      idx <= 2'd0;
      fcnt <= 8'd0;
      phase <= 1'b0;
      frame <= 1'b0;
      dig_sel <= 4'hF;
      seg <= 8'hFF;
      a_sh <= A_time;
      b_sh <= B_time;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
      frame <= wrap;
      if (wrap) begin
        a_sh <= A_time;
        b_sh <= B_time;
        fcnt <= fcnt == 8'(BLINK_FRAMES - 1) ? 8'd0 : fcnt + 8'd1;
        if (fcnt == 8'(BLINK_FRAMES - 1)) phase <= ~phase;
      end
      dig_sel <= ~(4'b0001 << idx);
      seg <= blank ? 8'hFF : {1'b1, code};
    end
  end
endmodule

// File: doc/traffic_display.md
# traffic_display

Downstream display stage for the intersection controller. It takes the controller's main-road and side-road countdown values and drives a 4-digit multiplexed common-anode 7-segment display. It snapshots both values once per scan frame so a digit never shows a half-updated value. It also splits each value into tens and ones and can blink the whole display.

## Interface

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays selected; legal range 2..2^20.
- BLINK_FRAMES, 32: frames per blink half-period; legal range 1..255.
- BLANK_LZ, 1: 1 blanks a tens digit whose value is 0; 0 shows it as '0'.

Ports:
- CLK, input, 1: system clock; all state changes on its rising edge.
- RST, input, 1: synchronous, active-high reset.
- A_time, input, 6: main-road countdown, unsigned, 0..63.
- B_time, input, 6: side-road countdown, unsigned, 0..63.
- BLINK, input, 1: 1 enables blanking during the blink-off phase.
- dig_sel, output, 4: digit enables, active-low, one-hot-low. Bit 0 = A tens, 1 = A ones, 2 = B tens, 3 = B ones.
- seg, output, 8: segments, active-low. seg[7] = dp, seg[6:0] = g..a.
- frame, output, 1: one-cycle pulse at each frame boundary.

## Operation

- Prescaler pre_cnt counts 0..SCAN_DIV-1 and wraps. tick = (pre_cnt == SCAN_DIV-1).
- Digit index idx (2 bits) advances 0→1→2→3→0 on each tick edge.
- Snapshot registers a_sh and b_sh:
  - Load A_time and B_time on the edge where idx wraps 3→0.
  - Also load them on every cycle while RST is high, so the first frame after reset shows live values.
  - Inputs are ignored at all other times.
- frame is registered. It is 1 for exactly the cycle following the 3→0 wrap edge, coincident with idx = 0 and the new snapshot.
- Digit values, computed from the snapshot:
  - tens = v/10, range 0..6.
  - ones = v%10, range 0..9.
  - Pure 6-bit arithmetic, no saturation; 63 displays "63".
- Segment codes, seg[6:0] active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - dp is always off (seg[7]=1).
- Blank conditions force seg = FF while dig_sel still scans normally:
  - BLANK_LZ=1 and the selected digit is a tens digit with value 0.
  - BLINK=1 and blink phase = 1.
- Blink phase:
  - A frame counter counts 3→0 wraps.
  - Phase toggles on the wrap that completes BLINK_FRAMES frames, then the counter clears.
  - The counter runs even when BLINK=0. Phase therefore stays free-running and deasserting BLINK restores the display within one cycle.
- seg and dig_sel are registered. Each cycle they are computed from the current idx, snapshot and BLINK.

## Timing

- Reset (RST high at an edge):
  - pre_cnt=0, idx=0, frame counter=0, blink phase=0, frame=0.
  - dig_sel=F (all off), seg=FF (all off).
  - a_sh/b_sh take the inputs on that edge.
  - Reset mid-frame aborts the scan. The display restarts at digit 0 with no frame pulse.
- First edge after RST falls: outputs show digit 0, so dig_sel=E.
- Output latency: one cycle from an idx change to the matching dig_sel/seg change. Each digit is driven for exactly SCAN_DIV cycles.
- Frame period: 4*SCAN_DIV cycles. The first frame pulse comes 4*SCAN_DIV cycles after reset release.
- Input changes between snapshots do not appear until the next frame. Worst-case display latency is 4*SCAN_DIV+1 cycles.
- BLINK is sampled every cycle; its effect is visible one cycle later.
- Blink half-period: BLINK_FRAMES*4*SCAN_DIV cycles.
- No combinational path from any input to any output.

## Test plan

- Basic scan (SCAN_DIV=4, BLANK_LZ=1), A=27, B=3 held through reset:
  - dig_sel must step E,D,B,7, each held 4 cycles.
  - seg must step A4, F8, FF, B0.
  - frame must pulse every 16 cycles.
- Snapshot isolation: A changes 27→26 at the second cycle of digit 1.
  - Digit 1 must stay F8 for the rest of the frame.
  - After the next frame pulse, digit 1 must show 82 (the code for '6').
- Range and leading-zero control:
  - A=63, B=0 with BLANK_LZ=1 → seg must read 82, B0, FF, C0.
  - Same inputs with BLANK_LZ=0 → digit 2 must read C0.
- Blink (BLINK_FRAMES=2), BLINK=1:
  - Frames 0-1 must show normal seg; frames 2-3 must show seg=FF throughout while dig_sel keeps scanning.
  - Dropping BLINK to 0 mid-phase must restore seg on the next cycle.
- Reset mid-operation: assert RST for 1 cycle during digit 2.
  - Next cycle must give dig_sel=F and seg=FF.
  - The cycle after that must give dig_sel=E.
  - No frame pulse until 16 cycles later.
- Prescaler boundary at SCAN_DIV=2: each digit must be held exactly 2 cycles, and frame must pulse every 8 cycles.
